// File: rtl/pll_mode_ctrl.sv
// pll_mode_ctrl: PLL mode sequencer (divider programming, reset pulse, lock wait, settle, run), optional retry via PLL_LOCK_RETRY_EN
module pll_mode_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  input  logic       req_mode,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic       cur_mode,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic       out_rstn
);
  localparam int M0   = RST_CYCLES > 4 ? RST_CYCLES : 4;
  localparam int M1   = M0 > LOCK_TIMEOUT ? M0 : LOCK_TIMEOUT;
  localparam int MAXC = M1 > SETTLE_CYCLES ? M1 : SETTLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [2:0] {INIT, HOLD, PLLRST, WAITLOCK, SETTLE, RUN, FAIL} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] sync;
  logic lock_s, mode_n, same_req, timeout;
  logic [5:0] id_m, fb_m, od_m;
`ifdef PLL_LOCK_RETRY_EN
  logic [1:0] att, att_n;
`endif
  assign lock_s  = sync[1];
  assign timeout = cnt == CW'(LOCK_TIMEOUT - 1);
  assign id_m    = cur_mode ? ~6'd3 : ~6'd2;
  assign fb_m    = cur_mode ? ~6'd54 : ~6'd13;
  assign od_m    = cur_mode ? 6'b111111 : 6'b111100;
  // next-state logic; the shared counter restarts on every state change and saturates otherwise
  always_comb begin
    state_n  = state;
    cnt_n    = (cnt == '1) ? cnt : cnt + CW'(1);
    mode_n   = cur_mode;
    same_req = 1'b0;
`ifdef PLL_LOCK_RETRY_EN
    att_n    = att;
`endif
    case (state)
      INIT: begin
        state_n = HOLD;
        mode_n  = 1'b1;
      end
      HOLD:   state_n = (cnt == CW'(3)) ? PLLRST : HOLD;
      PLLRST: state_n = (cnt == CW'(RST_CYCLES - 1)) ? WAITLOCK : PLLRST;
      WAITLOCK: begin
        if (lock_s) state_n = SETTLE;
        else if (timeout) begin
`ifdef PLL_LOCK_RETRY_EN
          state_n = (att == 2'd2) ? FAIL : PLLRST;
          att_n   = (att == 2'd2) ? att : att + 2'd1;
`else
          state_n = FAIL;
`endif
        end
      end
      SETTLE: begin
        if (!lock_s) cnt_n = '0;
        else if (cnt == CW'(SETTLE_CYCLES - 1)) state_n = RUN;
      end
      RUN: begin
        if (req_valid && req_mode != cur_mode) begin
          state_n = HOLD;
          mode_n  = req_mode;
        end else if (!lock_s) state_n = HOLD;
        else same_req = req_valid;
      end
      FAIL: begin
        if (req_valid) begin
          state_n = HOLD;
          mode_n  = req_mode;
`ifdef PLL_LOCK_RETRY_EN
          att_n   = 2'd0;
`endif
        end
      end
      default: state_n = INIT;
    endcase
    if (state_n != state) cnt_n = '0;
`ifdef PLL_LOCK_RETRY_EN
    if (state_n == RUN) att_n = 2'd0;
`endif
  end
  // state, counter, lock synchronizer and mode register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= INIT;
      cnt      <= '0;
      sync     <= 2'b00;
      cur_mode <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sync     <= {sync[0], pll_lock};
      cur_mode <= mode_n;
    end
  end
  // registered outputs decoded from the next state so they change with the state and never glitch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pll_reset <= 1'b1;
      out_rstn  <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      fail      <= 1'b0;
      idsel     <= ~6'd3;
      fbdsel    <= ~6'd54;
      odsel     <= 6'b111111;
    end else begin
      pll_reset <= state_n == INIT || state_n == PLLRST;
      out_rstn  <= state_n == RUN;
      busy      <= !(state_n == RUN || state_n == FAIL);
      done      <= (state_n == RUN && state != RUN) || same_req;
      fail      <= state_n == FAIL;
      idsel     <= state == HOLD ? id_m : idsel;
      fbdsel    <= state == HOLD ? fb_m : fbdsel;
      odsel     <= state == HOLD ? od_m : odsel;
    end
  end
`ifdef PLL_LOCK_RETRY_EN
  // lock attempt counter, bounded at the final attempt
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) att <= 2'd0;
    else att <= att_n;
  end
`endif
endmodule

// File: tb/tb_pll_mode_ctrl.sv
// tb_pll_mode_ctrl: scoreboard bench for pll_mode_ctrl with a behavioural PLL lock model
`timescale 1ns/1ps
module tb_pll_mode_ctrl;
  logic clk = 0, resetn = 0, req_valid = 0, req_mode = 0;
  logic busy, done, fail, cur_mode, pll_reset, out_rstn;
  logic [5:0] idsel, fbdsel, odsel;
  logic model_lock = 0, kill = 0, lock_en = 1, fail_d = 0;
  logic pll_lock;
  int lcnt = 0;
  int tests = 0, fails = 0;
  typedef struct packed {logic kind; logic mode;} rec_t;
  rec_t sb[$];
  rec_t r;
`ifdef PLL_LOCK_RETRY_EN
  localparam int EXP_PULSES = 3;
`else
  localparam int EXP_PULSES = 1;
`endif

  pll_mode_ctrl #(.RST_CYCLES(4), .LOCK_TIMEOUT(100), .SETTLE_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_mode(req_mode),
    .busy(busy), .done(done), .fail(fail), .cur_mode(cur_mode),
    .pll_lock(pll_lock), .pll_reset(pll_reset), .idsel(idsel), .fbdsel(fbdsel),
    .odsel(odsel), .out_rstn(out_rstn)
  );

  always #5 clk = ~clk;

  assign pll_lock = model_lock && !kill;

  // PLL model: lock drops while in reset and comes up 10 cycles after reset falls
  always @(posedge clk) begin
    if (pll_reset || !lock_en) begin
      model_lock <= 0;
      lcnt <= 0;
    end else if (lcnt >= 9) model_lock <= 1;
    else lcnt <= lcnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic k, input logic m);
    return rec_t'({k, m});
  endfunction

  // monitor: every done pulse or fail rise consumes one expected event
  always @(negedge clk) begin
    if (done || (fail && !fail_d)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got done=%0b fail=%0b expected no event at %0t", done, fail, $time);
      end else begin
        r = sb.pop_front();
        check("ev_kind", {31'b0, !done}, {31'b0, r.kind});
        check("ev_mode", cur_mode, r.mode);
        check("ev_idsel", idsel, r.mode ? 6'b111100 : 6'b111101);
        check("ev_fbdsel", fbdsel, r.mode ? 6'b001001 : 6'b110010);
        check("ev_odsel", odsel, r.mode ? 6'b111111 : 6'b111100);
        check("ev_out_rstn", out_rstn, !r.kind);
        check("ev_busy", busy, 0);
        check("ev_pll_reset", pll_reset, 0);
      end
    end
    fail_d = fail;
  end

  task automatic req(input logic m);
    @(negedge clk);
    req_valid = 1;
    req_mode = m;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, busy, 0);
    @(negedge clk);
  endtask

  task automatic pulse_width(output int w);
    int n = 0;
    w = 0;
    while (pll_reset && n < 100) begin @(negedge clk); n++; end
    while (!pll_reset && n < 100) begin @(negedge clk); n++; end
    while (pll_reset && n < 100) begin w++; @(negedge clk); n++; end
  endtask

  task automatic reset_vals(input string name);
    check({name, "_pll_reset"}, pll_reset, 1);
    check({name, "_out_rstn"}, out_rstn, 0);
    check({name, "_busy"}, busy, 1);
    check({name, "_done"}, done, 0);
    check({name, "_fail"}, fail, 0);
    check({name, "_cur_mode"}, cur_mode, 1);
    check({name, "_idsel"}, idsel, 6'b111100);
    check({name, "_fbdsel"}, fbdsel, 6'b001001);
    check({name, "_odsel"}, odsel, 6'b111111);
  endtask

  initial begin
    int w, n, p;
    logic prev;
    repeat (3) @(negedge clk);
    reset_vals("rst");
    sb.push_back(mk(0, 1));
    resetn = 1;
    pulse_width(w);
    check("init_prst_width", w, 4);
    wait_idle("bringup");
    check("bringup_out_rstn", out_rstn, 1);
    check("bringup_mode", cur_mode, 1);
    check("bringup_sb", sb.size(), 0);

    sb.push_back(mk(0, 0));
    req(0);
    check("sw_out_rstn_low", out_rstn, 0);
    check("sw_busy", busy, 1);
    pulse_width(w);
    check("sw_prst_width", w, 4);
    check("sw_idsel", idsel, 6'b111101);
    check("sw_fbdsel", fbdsel, 6'b110010);
    check("sw_odsel", odsel, 6'b111100);
    wait_idle("sw0");
    check("sw_mode", cur_mode, 0);

    sb.push_back(mk(0, 1));
    req(1);
    n = 0;
    while (!pll_reset && n < 50) begin @(negedge clk); n++; end
    while (pll_reset && n < 50) begin @(negedge clk); n++; end
    while (!pll_lock && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!done && n < 60) begin
      if (n == 6) kill = 1;
      if (n == 7) kill = 0;
      @(negedge clk);
      n++;
    end
    check("glitch_done_lat", n, 17);
    wait_idle("glitch");
    check("glitch_sb", sb.size(), 0);

    sb.push_back(mk(0, 1));
    @(negedge clk);
    kill = 1;
    n = 0;
    while (out_rstn && n < 10) begin @(negedge clk); n++; end
    check("loss_lat_ok", (n >= 1 && n <= 3), 1);
    check("loss_busy", busy, 1);
    check("loss_mode", cur_mode, 1);
    @(negedge clk);
    kill = 0;
    wait_idle("relock");
    check("relock_mode", cur_mode, 1);

    sb.push_back(mk(0, 1));
    req(1);
    check("same_done", done, 1);
    check("same_busy", busy, 0);
    check("same_out_rstn", out_rstn, 1);
    @(negedge clk);
    check("same_done_pulse", done, 0);
    check("same_sb", sb.size(), 0);

    sb.push_back(mk(0, 0));
    @(negedge clk);
    kill = 1;
    @(negedge clk);
    @(negedge clk);
    req_valid = 1;
    req_mode = 0;
    @(negedge clk);
    req_valid = 0;
    kill = 0;
    check("lossreq_mode", cur_mode, 0);
    check("lossreq_busy", busy, 1);
    wait_idle("lossreq");
    repeat (20) @(negedge clk);
    check("lossreq_sb", sb.size(), 0);

    lock_en = 0;
    sb.push_back(mk(1, 1));
    req(1);
    prev = pll_reset;
    p = 0;
    n = 0;
    while (!fail && n < 1500) begin
      @(negedge clk);
      n++;
      if (pll_reset && !prev) p++;
      prev = pll_reset;
    end
    check("nolock_pulses", p, EXP_PULSES);
    check("nolock_fail", fail, 1);
    repeat (5) @(negedge clk);
    check("nolock_sticky", fail, 1);
    check("nolock_out_rstn", out_rstn, 0);
    check("nolock_pll_reset", pll_reset, 0);

    lock_en = 1;
    req(0);
    check("fail_clear", fail, 0);
    check("fail_busy", busy, 1);
    check("fail_mode", cur_mode, 0);
    n = 0;
    while (!pll_reset && n < 50) begin @(negedge clk); n++; end
    check("pre_rst_pll_reset", pll_reset, 1);
    check("pre_rst_idsel", idsel, 6'b111101);
    #2 resetn = 0;
    #1 reset_vals("arst");
    repeat (2) @(negedge clk);
    reset_vals("arst_hold");
    sb.push_back(mk(0, 1));
    resetn = 1;
    @(negedge clk);
    wait_idle("final");
    check("final_sb", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pll_mode_ctrl.md
PLL_MODE_CTRL -- requirements
Module: pll_mode_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles pll_reset is held high per attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum cycles to wait for lock.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1024: cycles lock must stay continuously high before release.
REQ-004 SHALL have port clk, input, 1 bit: 27 MHz crystal clock.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1 bit: single-cycle mode-change request.
REQ-007 SHALL have port req_mode, input, 1 bit: 0 = VGA (126 MHz TMDS), 1 = 720p (371.25 MHz).
REQ-008 SHALL have port busy, output, 1 bit: sequence in progress; requests are ignored while high.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse on entering RUN.
REQ-010 SHALL have port fail, output, 1 bit: sticky lock failure flag.
REQ-011 SHALL have port cur_mode, output, 1 bit: mode currently programmed.
REQ-012 SHALL have port pll_lock, input, 1 bit: PLL LOCK, asynchronous to clk.
REQ-013 SHALL have port pll_reset, output, 1 bit: PLL RESET, active-high.
REQ-014 SHALL have port idsel, output, 6 bits: PLL IDSEL.
REQ-015 SHALL have port fbdsel, output, 6 bits: PLL FBDSEL.
REQ-016 SHALL have port odsel, output, 6 bits: PLL ODSEL.
REQ-017 SHALL have port out_rstn, output, 1 bit: active-low reset for the pixel/TMDS domains.

Function
REQ-018 SHALL pass pll_lock through a 2-FF synchronizer; every lock decision SHALL use the synchronized value lock_s.
REQ-019 SHALL use states INIT, HOLD, PLLRST, WAITLOCK, SETTLE, RUN, FAIL.
REQ-020 SHALL drive mode 0 divider outputs as idsel = ~6'd2, fbdsel = ~6'd13, odsel = 6'b111100 (ODIV 8).
REQ-021 SHALL drive mode 1 divider outputs as idsel = ~6'd3, fbdsel = ~6'd54, odsel = 6'b111111 (ODIV 2).
REQ-022 SHALL, in INIT (entered after reset), load cur_mode = 1 and go to HOLD on the next cycle.
REQ-023 SHALL, in RUN, on req_valid with req_mode != cur_mode: latch req_mode into cur_mode, deassert out_rstn, and go to HOLD.
REQ-024 SHALL, in RUN, on req_valid with req_mode == cur_mode: stay in RUN and emit done one cycle later.
REQ-025 SHALL, in HOLD, keep out_rstn low for 4 cycles, then go to PLLRST.
REQ-026 SHALL update idsel, fbdsel and odsel only in HOLD, so they are stable before pll_reset rises.
REQ-027 SHALL, in PLLRST, hold pll_reset = 1 for exactly RST_CYCLES cycles, then go to WAITLOCK with pll_reset = 0.
REQ-028 SHALL, in WAITLOCK, go to SETTLE when lock_s = 1.
REQ-029 SHALL, in WAITLOCK, treat LOCK_TIMEOUT cycles without lock as a timeout (handled per REQ-037/038).
REQ-030 SHALL, in SETTLE, count consecutive lock_s = 1 cycles; a 0 restarts the count from zero.
REQ-031 SHALL, in SETTLE, go to RUN when the count reaches SETTLE_CYCLES, setting out_rstn = 1 and pulsing done.
REQ-032 SHALL, in RUN, on lock_s falling, deassert out_rstn within 1 cycle and go to HOLD, keeping the same mode (auto-relock).
REQ-033 SHALL, when a lock loss and req_valid occur in the same cycle, take the request's mode and run one sequence.
REQ-034 SHALL drive busy = 1 in every state except RUN and FAIL.
REQ-035 SHALL make all counters saturate and never wrap.

Reset
REQ-036 SHALL, while resetn = 0 (including mid-sequence), force: state INIT, pll_reset = 1, out_rstn = 0, busy = 1, done = 0, fail = 0, cur_mode = 1, dividers = mode 1 values, synchronizer = 0.

Configuration
REQ-037 SHALL, when PLL_LOCK_RETRY_EN is defined, respond to a WAITLOCK timeout by returning to PLLRST, up to 3 attempts total; after the third timeout it SHALL go to FAIL and set fail = 1. The attempt counter SHALL clear on entering RUN.
REQ-038 SHALL, when PLL_LOCK_RETRY_EN is undefined, respond to the first WAITLOCK timeout by going directly to FAIL with fail = 1.
REQ-039 SHALL, in FAIL, hold out_rstn = 0 and pll_reset = 0; a req_valid SHALL clear fail and restart at HOLD with req_mode.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=8)
REQ-040 SHALL cover: reset release with lock rising 10 cycles after pll_reset falls -> out_rstn high, done pulsed, idsel = 6'b111100, fbdsel = 6'b001001, cur_mode = 1.
REQ-041 SHALL cover: req_valid with req_mode = 0 in RUN -> out_rstn low next cycle, pll_reset high for exactly 4 cycles, idsel = 6'b111101, fbdsel = 6'b110010, odsel = 6'b111100.
REQ-042 SHALL cover: lock glitching low for 1 cycle at SETTLE count 5 -> count restarts, RUN entered only after 8 consecutive high cycles.
REQ-043 SHALL cover: lock dropping in RUN -> out_rstn low within 3 cycles of the pll_lock edge, re-sequence in the same mode.
REQ-044 SHALL cover: lock never asserted -> with macro defined, 3 pll_reset pulses then fail = 1; without it, 1 pulse then fail = 1.
REQ-045 SHALL cover: resetn asserted during PLLRST -> all outputs at reset values immediately (asynchronously).
